// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bundle: decoder redirect/stall inputs, ROM port, instruction output
interface fetch_unit_if #(
    parameter int ADDR_W = 10
) ();
    logic              wStall;
    logic              wBranchTaken;
    logic              wJumpTaken;
    logic [ADDR_W-1:0] wBranchDir;
    logic [15:0]       wRomData;
    logic [ADDR_W-1:0] oRomAddr;
    logic [15:0]       oInstruction;
    logic              oInstrValid;
    logic [ADDR_W-1:0] oPC;

    // Fetch unit side
    modport master (
        input  wStall, wBranchTaken, wJumpTaken, wBranchDir, wRomData,
        output oRomAddr, oInstruction, oInstrValid, oPC
    );

    // Decoder / ROM side
    modport slave (
        output wStall, wBranchTaken, wJumpTaken, wBranchDir, wRomData,
        input  oRomAddr, oInstruction, oInstrValid, oPC
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with redirect flush and one-entry stall skid; optional FETCH_REL_BRANCH_EN
module fetch_unit #(
    parameter int                ADDR_W   = 10,
    parameter logic [15:0]       NOP      = 16'h0000,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         Clock,
    input  logic         Reset,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {ST_START, ST_RUN, ST_FLUSH} state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [15:0]       r_instr, w_instr_next;
    logic              r_valid, w_valid_next;
    logic [ADDR_W-1:0] r_opc, w_opc_next;
    logic              r_skid_valid, w_skid_valid_next;
    logic [15:0]       r_skid_data, w_skid_data_next;
    logic [ADDR_W-1:0] r_skid_addr, w_skid_addr_next;

    logic [ADDR_W-1:0] w_data_addr;
    logic [ADDR_W-1:0] w_branch_target;
    logic [ADDR_W-1:0] w_target;
    logic              w_redirect;

    // In RUN the ROM data on the input belongs to the address issued last cycle
    assign w_data_addr = r_pc - 1'b1;
    assign w_redirect  = bus.wJumpTaken | bus.wBranchTaken;

`ifdef FETCH_REL_BRANCH_EN
    // The delay slot is on the output, so oPC is branch address + 1
    assign w_branch_target = r_opc + {{(ADDR_W-7){bus.wBranchDir[6]}}, bus.wBranchDir[6:0]};
`else
    assign w_branch_target = bus.wBranchDir;
`endif

    assign w_target = bus.wJumpTaken ? bus.wBranchDir : w_branch_target;

    assign bus.oRomAddr     = r_pc;
    assign bus.oInstruction = r_instr;
    assign bus.oInstrValid  = r_valid;
    assign bus.oPC          = r_opc;

    // Register state, PC, output stage and skid entry
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state      <= ST_START;
            r_pc         <= RESET_PC;
            r_instr      <= NOP;
            r_valid      <= 1'b0;
            r_opc        <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= NOP;
            r_skid_addr  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_instr      <= w_instr_next;
            r_valid      <= w_valid_next;
            r_opc        <= w_opc_next;
            r_skid_valid <= w_skid_valid_next;
            r_skid_data  <= w_skid_data_next;
            r_skid_addr  <= w_skid_addr_next;
        end
    end

    // Next-state and datapath selection; redirect outranks stall
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_instr_next      = r_instr;
        w_valid_next      = r_valid;
        w_opc_next        = r_opc;
        w_skid_valid_next = r_skid_valid;
        w_skid_data_next  = r_skid_data;
        w_skid_addr_next  = r_skid_addr;
        case (r_state)
            ST_START: begin
                w_pc_next    = r_pc + 1'b1;
                w_instr_next = NOP;
                w_valid_next = 1'b0;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_redirect) begin
                    w_pc_next         = w_target;
                    w_instr_next      = NOP;
                    w_valid_next      = 1'b0;
                    w_skid_valid_next = 1'b0;
                    w_state_next      = ST_FLUSH;
                end else if (bus.wStall) begin
                    // Capture only on the first stall edge; the ROM keeps re-reading the same address
                    if (!r_skid_valid) begin
                        w_skid_valid_next = 1'b1;
                        w_skid_data_next  = bus.wRomData;
                        w_skid_addr_next  = w_data_addr;
                    end
                end else begin
                    w_instr_next      = r_skid_valid ? r_skid_data : bus.wRomData;
                    w_opc_next        = r_skid_valid ? r_skid_addr : w_data_addr;
                    w_valid_next      = 1'b1;
                    w_pc_next         = r_pc + 1'b1;
                    w_skid_valid_next = 1'b0;
                end
            end
            ST_FLUSH: begin
                // ROM data is wrong-path and decoder flags are stale delay-slot decode
                w_instr_next = NOP;
                w_valid_next = 1'b0;
                w_pc_next    = r_pc + 1'b1;
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_START;
            end
        endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit with a synchronous ROM model
module tb_fetch_unit;
    logic        clk;
    logic        rst;
    logic [15:0] mem [0:1023];
    logic [15:0] rom_data;
    int          checks;
    int          errors;

    fetch_unit_if #(.ADDR_W(10)) bus ();

    fetch_unit dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[bus.oRomAddr];
    assign bus.wRomData = rom_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to_opc(input int target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 1100; n++) begin
            if (bus.oInstrValid && bus.oPC == target[9:0]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.oInstruction !== 16'h0000 || bus.oInstrValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: instr=%h valid=%b, required 0000/0", bus.oInstruction, bus.oInstrValid);
        end
        checks++;
        if (bus.oRomAddr !== 10'd0 || bus.oPC !== 10'd0) begin
            errors++;
            $display("FAIL reset_addr: romaddr=%0d pc=%0d, required 0/0", bus.oRomAddr, bus.oPC);
        end
    endtask

    task automatic test_startup(input string tag);
        rst = 1'b1;
        checks++;
        if (bus.oRomAddr !== 10'd0) begin
            errors++;
            $display("FAIL %s_start_addr: %0d, required 0", tag, bus.oRomAddr);
        end
        tick();
        checks++;
        if (bus.oRomAddr !== 10'd1 || bus.oInstrValid !== 1'b0) begin
            errors++;
            $display("FAIL %s_edge1: addr=%0d valid=%b, required 1/0", tag, bus.oRomAddr, bus.oInstrValid);
        end
        tick();
        checks++;
        if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== 16'h1000 || bus.oPC !== 10'd0 || bus.oRomAddr !== 10'd2) begin
            errors++;
            $display("FAIL %s_first: valid=%b instr=%h pc=%0d addr=%0d, required 1/1000/0/2",
                     tag, bus.oInstrValid, bus.oInstruction, bus.oPC, bus.oRomAddr);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== (16'h1000 + 16'(i)) || bus.oPC !== 10'(i)) begin
                errors++;
                $display("FAIL %s_seq%0d: valid=%b instr=%h pc=%0d, required 1/%h/%0d",
                         tag, i, bus.oInstrValid, bus.oInstruction, bus.oPC, 16'h1000 + 16'(i), i);
            end
        end
    endtask

    task automatic test_stall();
        bus.wStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== 16'h1005 || bus.oPC !== 10'd5) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b instr=%h pc=%0d, required 1/1005/5",
                         i, bus.oInstrValid, bus.oInstruction, bus.oPC);
            end
        end
        bus.wStall = 1'b0;
        for (int i = 6; i <= 7; i++) begin
            tick();
            checks++;
            if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== (16'h1000 + 16'(i)) || bus.oPC !== 10'(i)) begin
                errors++;
                $display("FAIL stall_release%0d: valid=%b instr=%h pc=%0d, required 1/%h/%0d",
                         i, bus.oInstrValid, bus.oInstruction, bus.oPC, 16'h1000 + 16'(i), i);
            end
        end
    endtask

    task automatic test_jump();
        bit ok;
        advance_to_opc(21, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL jump_reach: oPC 21 not reached, required reached");
        end
        bus.wJumpTaken = 1'b1;
        bus.wBranchDir = 10'h200;
        tick();
        bus.wJumpTaken = 1'b0;
        checks++;
        if (bus.oInstruction !== 16'h0000 || bus.oInstrValid !== 1'b0 || bus.oRomAddr !== 10'h200) begin
            errors++;
            $display("FAIL jump_bubble1: instr=%h valid=%b addr=%h, required 0000/0/200",
                     bus.oInstruction, bus.oInstrValid, bus.oRomAddr);
        end
        bus.wBranchTaken = 1'b1;
        bus.wBranchDir   = 10'h050;
        tick();
        bus.wBranchTaken = 1'b0;
        checks++;
        if (bus.oInstruction !== 16'h0000 || bus.oInstrValid !== 1'b0 || bus.oRomAddr !== 10'h201) begin
            errors++;
            $display("FAIL jump_bubble2: instr=%h valid=%b addr=%h, required 0000/0/201",
                     bus.oInstruction, bus.oInstrValid, bus.oRomAddr);
        end
        tick();
        checks++;
        if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== 16'h1200 || bus.oPC !== 10'h200) begin
            errors++;
            $display("FAIL jump_target: valid=%b instr=%h pc=%h, required 1/1200/200",
                     bus.oInstrValid, bus.oInstruction, bus.oPC);
        end
        tick();
        checks++;
        if (bus.oInstruction !== 16'h1201 || bus.oPC !== 10'h201) begin
            errors++;
            $display("FAIL jump_next: instr=%h pc=%h, required 1201/201", bus.oInstruction, bus.oPC);
        end
    endtask

    task automatic test_both_redirect();
        bus.wStall = 1'b1;
        tick();
        bus.wJumpTaken   = 1'b1;
        bus.wBranchTaken = 1'b1;
        bus.wBranchDir   = 10'h300;
        tick();
        bus.wJumpTaken   = 1'b0;
        bus.wBranchTaken = 1'b0;
        bus.wStall       = 1'b0;
        checks++;
        if (bus.oInstruction !== 16'h0000 || bus.oInstrValid !== 1'b0 || bus.oRomAddr !== 10'h300) begin
            errors++;
            $display("FAIL both_redirect: instr=%h valid=%b addr=%h, required 0000/0/300",
                     bus.oInstruction, bus.oInstrValid, bus.oRomAddr);
        end
        tick();
        tick();
        checks++;
        if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== 16'h1300 || bus.oPC !== 10'h300) begin
            errors++;
            $display("FAIL both_target: valid=%b instr=%h pc=%h, required 1/1300/300",
                     bus.oInstrValid, bus.oInstruction, bus.oPC);
        end
        tick();
        checks++;
        if (bus.oInstruction !== 16'h1301 || bus.oPC !== 10'h301) begin
            errors++;
            $display("FAIL both_next: instr=%h pc=%h, required 1301/301", bus.oInstruction, bus.oPC);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 1100; n++) begin
            if (bus.oRomAddr == 10'd1023) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        checks++;
        if (!ok || bus.oRomAddr !== 10'd0) begin
            errors++;
            $display("FAIL wrap_addr: reached=%b addr=%0d, required 1/0", ok, bus.oRomAddr);
        end
        advance_to_opc(1023, ok);
        checks++;
        if (!ok || bus.oInstruction !== 16'h13FF) begin
            errors++;
            $display("FAIL wrap_last: reached=%b instr=%h, required 1/13ff", ok, bus.oInstruction);
        end
        tick();
        checks++;
        if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== 16'h1000 || bus.oPC !== 10'd0) begin
            errors++;
            $display("FAIL wrap_first: valid=%b instr=%h pc=%0d, required 1/1000/0",
                     bus.oInstrValid, bus.oInstruction, bus.oPC);
        end
    endtask

    task automatic test_reset_mid();
        bus.wJumpTaken = 1'b1;
        bus.wBranchDir = 10'h100;
        tick();
        bus.wJumpTaken = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (bus.oInstruction !== 16'h0000 || bus.oInstrValid !== 1'b0 || bus.oRomAddr !== 10'd0) begin
            errors++;
            $display("FAIL reset_flush: instr=%h valid=%b addr=%0d, required 0000/0/0",
                     bus.oInstruction, bus.oInstrValid, bus.oRomAddr);
        end
        test_startup("restart_flush");
        bus.wStall = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        bus.wStall = 1'b0;
        checks++;
        if (bus.oInstruction !== 16'h0000 || bus.oInstrValid !== 1'b0 || bus.oRomAddr !== 10'd0) begin
            errors++;
            $display("FAIL reset_stall: instr=%h valid=%b addr=%0d, required 0000/0/0",
                     bus.oInstruction, bus.oInstrValid, bus.oRomAddr);
        end
        test_startup("restart_stall");
    endtask

    task automatic test_branch();
        bit ok;
        advance_to_opc(41, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL branch_reach: oPC 41 not reached, required reached");
        end
        bus.wBranchTaken = 1'b1;
`ifdef FETCH_REL_BRANCH_EN
        bus.wBranchDir   = 10'h07E;
`else
        bus.wBranchDir   = 10'd39;
`endif
        tick();
        bus.wBranchTaken = 1'b0;
        checks++;
        if (bus.oInstrValid !== 1'b0 || bus.oRomAddr !== 10'd39) begin
            errors++;
            $display("FAIL branch_bubble: valid=%b addr=%0d, required 0/39", bus.oInstrValid, bus.oRomAddr);
        end
        tick();
        tick();
        checks++;
        if (bus.oInstrValid !== 1'b1 || bus.oInstruction !== 16'h1027 || bus.oPC !== 10'd39) begin
            errors++;
            $display("FAIL branch_target: valid=%b instr=%h pc=%0d, required 1/1027/39",
                     bus.oInstrValid, bus.oInstruction, bus.oPC);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h1000 + 16'(i);
        rst              = 1'b0;
        bus.wStall       = 1'b0;
        bus.wBranchTaken = 1'b0;
        bus.wJumpTaken   = 1'b0;
        bus.wBranchDir   = '0;
        test_reset();
        test_startup("startup");
        test_stall();
        test_jump();
        test_both_redirect();
        test_wrap();
        test_reset_mid();
        test_branch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
